// File: rtl/fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : fifo_drain
// Description : Pops a burst of len words from an upstream FIFO that has a
//               one-cycle read latency. The words are forwarded on a
//               valid/ready stream through a two-entry in-order holding
//               buffer. m_last marks the final word of the burst, and done
//               pulses one cycle after that word is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state;
    logic [LEN_W-1:0] r_issue_cnt;
    logic [LEN_W-1:0] r_out_cnt;
    logic [1:0]       r_occ;
    logic             r_inflight;
    logic [WIDTH-1:0] r_buf0;        // head entry
    logic [WIDTH-1:0] r_buf1;        // second entry, zero unless occ == 2
    logic             r_done;

    logic             w_run;
    logic             w_pop;
    logic             w_cap;
    logic [2:0]       w_level;
    logic             w_rd_en;

    // Read gating: a word is issued only when the buffer still has room for
    // it after counting words already held, the word in flight, and the word
    // leaving this cycle. This makes buffer overflow impossible.
    always_comb begin
        w_run   = (r_state == S_RUN);
        w_pop   = (r_occ != 2'd0) && m_ready;
        w_cap   = r_inflight;
        w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        w_rd_en = w_run && (r_issue_cnt != '0) && !fifo_empty && (w_level < 3'd2);
    end

    assign busy       = w_run;
    assign done       = r_done;
    assign fifo_rd_en = w_rd_en;
    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf0;
    assign m_last     = (r_occ != 2'd0) && (r_out_cnt == {{(LEN_W-1){1'b0}}, 1'b1});

    // Burst control: accept a request in IDLE, count issued and delivered words
    // in RUN, and return to IDLE on delivery of the last word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_issue_cnt <= '0;
            r_out_cnt   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start) begin
                    if (len != '0) begin
                        r_issue_cnt <= len;
                        r_out_cnt   <= len;
                        r_state     <= S_RUN;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else begin
                if (w_rd_en) begin
                    r_issue_cnt <= r_issue_cnt - 1'b1;
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt - 1'b1;
                    if (r_out_cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
            end
        end
    end

    // Read-latency tracker: the FIFO returns data the cycle after a pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
        end
    end

    // Holding buffer: capture returning words in order and shift toward the
    // head on each pop. A freed entry is zeroed so m_data reads 0 when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({w_cap, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_data;
                    end else begin
                        r_buf1 <= fifo_data;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_buf1 <= '0;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= fifo_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_data;
                    end
                end
                default: begin
                    r_occ <= r_occ;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_drain
// Description : Directed self-checking bench for fifo_drain with a behavioural
//               upstream FIFO (one-cycle read latency) and a stream monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_drain;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data = '0;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    int vectors    = 0;
    int miscompares = 0;

    // upstream FIFO model
    logic [31:0] mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_count = 0;
    logic        hold_empty = 1'b0;
    logic        fifo_flush = 1'b0;
    logic        underflow = 1'b0;

    // stream monitor
    logic [31:0] got [$];
    logic        got_last [$];
    logic [31:0] expw [$];

    fifo_drain #(.WIDTH(32), .LEN_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr) || hold_empty;

    always @(posedge clk) begin
        if (fifo_flush) begin
            rd_ptr    <= wr_ptr;
            fifo_data <= '0;
        end else if (fifo_rd_en) begin
            if (fifo_empty) underflow <= 1'b1;
            fifo_data <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
            rd_count  <= rd_count + 1;
        end else begin
            fifo_data <= '0;
        end
        if (!rst && m_valid && m_ready) begin
            got.push_back(m_data);
            got_last.push_back(m_last);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_it);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
        if (expect_it) expw.push_back(w);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k;
        k = 0;
        while (done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic chk_stream(input string tag, input int base, input int n);
        chk($sformatf("%s_count", tag), got.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (base + i < got.size()) begin
                chk($sformatf("%s_data%0d", tag, i), got[base+i], expw[i]);
                chk($sformatf("%s_last%0d", tag, i), {31'd0, got_last[base+i]}, {31'd0, (i == n-1)});
            end
        end
    endtask

    task automatic flush_fifo();
        fifo_flush = 1'b1;
        @(negedge clk);
        fifo_flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int rc0;
        rst = 1'b1; start = 1'b0; len = '0; m_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",    {31'd0, busy},       32'd0);
        chk("rst_done",    {31'd0, done},       32'd0);
        chk("rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_m_valid", {31'd0, m_valid},    32'd0);
        chk("rst_m_data",  m_data,              32'd0);
        chk("rst_m_last",  {31'd0, m_last},     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // back-to-back burst of 4, cycle-exact
        expw = {};
        push_word(32'hA000_000A, 1); push_word(32'hB000_000B, 1);
        push_word(32'hC000_000C, 1); push_word(32'hD000_000D, 1);
        base = got.size(); rc0 = rd_count;
        m_ready = 1'b1; start = 1'b1; len = 8'd4;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("s1_rd_en_c%0d", k),   {31'd0, fifo_rd_en}, {31'd0, (k <= 4)});
            chk($sformatf("s1_m_valid_c%0d", k), {31'd0, m_valid},    {31'd0, (k >= 3 && k <= 6)});
            if (k >= 3 && k <= 6) chk($sformatf("s1_m_data_c%0d", k), m_data, expw[k-3]);
            chk($sformatf("s1_m_last_c%0d", k),  {31'd0, m_last},     {31'd0, (k == 6)});
            chk($sformatf("s1_done_c%0d", k),    {31'd0, done},       {31'd0, (k == 7)});
            chk($sformatf("s1_busy_c%0d", k),    {31'd0, busy},       {31'd0, (k <= 6)});
        end
        chk_stream("s1", base, 4);
        chk("s1_reads", rd_count - rc0, 4);

        // backpressure: len 3, m_ready low for 5 cycles after first valid
        @(negedge clk);
        expw = {};
        push_word(32'h0000_1111, 1); push_word(32'h0000_2222, 1); push_word(32'h0000_3333, 1);
        base = got.size(); rc0 = rd_count;
        m_ready = 1'b0; start = 1'b1; len = 8'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int k = 3; k <= 7; k++) begin
            @(negedge clk);
            chk($sformatf("s2_valid_c%0d", k), {31'd0, m_valid}, 32'd1);
            chk($sformatf("s2_hold_c%0d", k),  m_data, 32'h0000_1111);
        end
        chk("s2_reads_stalled", rd_count - rc0, 2);
        m_ready = 1'b1;
        wait_done("s2_done", 20);
        chk_stream("s2", base, 3);
        chk("s2_reads", rd_count - rc0, 3);

        // upstream runs dry after 2 words for 3 cycles
        @(negedge clk);
        expw = {};
        push_word(32'h5555_0001, 1); push_word(32'h5555_0002, 1);
        base = got.size(); rc0 = rd_count;
        m_ready = 1'b1; start = 1'b1; len = 8'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        for (int k = 3; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("s3_rd_stall_c%0d", k), {31'd0, fifo_rd_en}, 32'd0);
        end
        push_word(32'h5555_0003, 1); push_word(32'h5555_0004, 1);
        wait_done("s3_done", 20);
        chk_stream("s3", base, 4);
        chk("s3_reads", rd_count - rc0, 4);

        // zero-length request
        @(negedge clk);
        rc0 = rd_count;
        start = 1'b1; len = 8'd0;
        @(negedge clk); start = 1'b0;
        chk("s4_done",  {31'd0, done}, 32'd1);
        chk("s4_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("s4_done_once", {31'd0, done}, 32'd0);
        chk("s4_busy2",     {31'd0, busy}, 32'd0);
        chk("s4_reads", rd_count - rc0, 0);

        // asynchronous reset in the middle of a burst
        @(negedge clk);
        expw = {};
        push_word(32'hDEAD_0001, 0); push_word(32'hDEAD_0002, 0);
        push_word(32'hDEAD_0003, 0); push_word(32'hDEAD_0004, 0);
        m_ready = 1'b0; start = 1'b1; len = 8'd4;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("s5_pre_valid", {31'd0, m_valid}, 32'd1);
        #2 rst = 1'b1; fifo_flush = 1'b1;
        #1;
        chk("s5_rst_busy",    {31'd0, busy},       32'd0);
        chk("s5_rst_done",    {31'd0, done},       32'd0);
        chk("s5_rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        chk("s5_rst_m_valid", {31'd0, m_valid},    32'd0);
        chk("s5_rst_m_data",  m_data,              32'd0);
        chk("s5_rst_m_last",  {31'd0, m_last},     32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; fifo_flush = 1'b0;
        @(negedge clk);
        push_word(32'hE000_000E, 1); push_word(32'hF000_000F, 1);
        base = got.size(); rc0 = rd_count;
        m_ready = 1'b1; start = 1'b1; len = 8'd2;
        @(negedge clk); start = 1'b0;
        wait_done("s5_done", 20);
        chk_stream("s5", base, 2);
        chk("s5_reads", rd_count - rc0, 2);

        // second start while running is ignored
        @(negedge clk);
        expw = {};
        push_word(32'h7000_0001, 1); push_word(32'h7000_0002, 1); push_word(32'h7000_0003, 1);
        push_word(32'h7000_0004, 0); push_word(32'h7000_0005, 0);
        base = got.size(); rc0 = rd_count;
        m_ready = 1'b1; start = 1'b1; len = 8'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; len = 8'd2;
        @(negedge clk); start = 1'b0;
        wait_done("s6_done", 20);
        @(negedge clk);
        @(negedge clk);
        chk("s6_idle", {31'd0, busy}, 32'd0);
        chk_stream("s6", base, 3);
        chk("s6_reads", rd_count - rc0, 3);
        chk("s6_left_in_fifo", wr_ptr - rd_ptr, 2);
        flush_fifo();

        chk("no_underflow", {31'd0, underflow}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
